// File: rtl/bls12_381_fe12_norm_fe6_pkg.sv
// bls12_381_fe12_norm_fe6_pkg: field word types, stream widths and norm-stage FSM states
package bls12_381_fe12_norm_fe6_pkg;
  localparam int FE_BITS = 381;
  localparam int CTL_BITS = 32;
  localparam int OVR_WRT_BIT = 8;
  localparam int FE6_WORDS = 6;
  localparam int FE12_WORDS = 12;
  typedef logic [FE_BITS-1:0] fe_t;
  typedef fe_t [FE12_WORDS-1:0] fe12_t;
  localparam fe_t P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam fe12_t FE12_one = fe12_t'(1);
  typedef enum logic [1:0] {LOAD, NEGATE, MULT, DRAIN} state_t;
  function automatic logic [CTL_BITS-1:0] tag_ctl(input logic [CTL_BITS-1:0] ctl, input logic [3:0] tag);
    tag_ctl = ctl;
    tag_ctl[OVR_WRT_BIT+:4] = tag;
  endfunction
endpackage

// File: rtl/bls12_381_fe12_norm_fe6_if.sv
// bls12_381_fe12_norm_fe6_if: valid/ready stream with sop/eop framing and ctl sideband
interface bls12_381_fe12_norm_fe6_if #(parameter int DAT_BITS = 381);
  import bls12_381_fe12_norm_fe6_pkg::*;
  logic val, rdy, sop, eop;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  modport master(output val, sop, eop, dat, ctl, input rdy);
  modport slave(input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/bls12_381_fe12_norm_fe6.sv
// bls12_381_fe12_norm_fe6: streams N = f*conj(f) = c0^2 - v*c1^2 using shared Fp subtractor and FE12 multiplier
module bls12_381_fe12_norm_fe6
  import bls12_381_fe12_norm_fe6_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  bls12_381_fe12_norm_fe6_if.slave  fe12_in,
  bls12_381_fe12_norm_fe6_if.master fe6_out,
  bls12_381_fe12_norm_fe6_if.master sub_req,
  bls12_381_fe12_norm_fe6_if.slave  sub_rsp,
  bls12_381_fe12_norm_fe6_if.master mul_req,
  bls12_381_fe12_norm_fe6_if.slave  mul_rsp,
  output logic err
);
  localparam logic [3:0] N6 = 4'(FE6_WORDS);
  localparam logic [3:0] LAST6 = 4'(FE6_WORDS - 1);
  localparam logic [3:0] LAST12 = 4'(FE12_WORDS - 1);
  state_t state, nxt;
  logic run, in_hs, sub_hs, rsp_hs, mul_hs, res_hs, frame_end, frame_ok;
  logic [3:0] cnt, rcnt, idx;
  logic [CTL_BITS-1:0] ctl_r;
  fe_t wbuf [FE12_WORDS];
  fe_t nbuf [FE6_WORDS];
  assign idx = fe12_in.sop ? 4'd0 : cnt;
  assign frame_end = fe12_in.eop | (idx == LAST12);
  assign frame_ok = fe12_in.eop & (idx == LAST12);
  assign in_hs = fe12_in.val & fe12_in.rdy;
  assign sub_hs = sub_req.val & sub_req.rdy;
  assign mul_hs = mul_req.val & mul_req.rdy;
  // responses outside their owning state are stale (e.g. after a reset) and are swallowed
  assign rsp_hs = sub_rsp.val & sub_rsp.rdy & (state == NEGATE);
  assign res_hs = mul_rsp.val & mul_rsp.rdy & (state == DRAIN);
  assign fe12_in.rdy = run & (state == LOAD);
  assign sub_rsp.rdy = run;
  assign mul_rsp.rdy = run & ((state != DRAIN) | (cnt >= N6) | ~fe6_out.val | fe6_out.rdy);
  assign sub_req.val = (state == NEGATE) & (cnt < N6);
  assign sub_req.dat = {wbuf[cnt + 4'd6], {FE_BITS{1'b0}}};
  assign sub_req.sop = 1'b1;
  assign sub_req.eop = 1'b1;
  assign sub_req.ctl = tag_ctl(ctl_r, cnt);
  assign mul_req.val = (state == MULT);
  assign mul_req.dat = {(cnt < N6) ? wbuf[cnt] : nbuf[3'(cnt - N6)], wbuf[cnt]};
  assign mul_req.sop = (cnt == 4'd0);
  assign mul_req.eop = (cnt == LAST12);
  assign mul_req.ctl = tag_ctl(ctl_r, cnt);
  always_comb begin
    nxt = state;
    case (state)
      LOAD:    nxt = (in_hs & frame_ok) ? NEGATE : LOAD;
      NEGATE:  nxt = (rsp_hs & (rcnt == LAST6)) ? MULT : NEGATE;
      MULT:    nxt = (mul_hs & (cnt == LAST12)) ? DRAIN : MULT;
      default: nxt = (res_hs & (cnt == LAST12)) ? LOAD : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD;
      run <= 1'b0;
      cnt <= '0;
      rcnt <= '0;
      err <= 1'b0;
      fe6_out.val <= 1'b0;
    end else begin
      state <= nxt;
      run <= 1'b1;
      err <= in_hs & frame_end & ~frame_ok;
      if (nxt != state) cnt <= '0;
      else if (in_hs) cnt <= frame_end ? 4'd0 : idx + 4'd1;
      else if (sub_hs | mul_hs | res_hs) cnt <= cnt + 4'd1;
      rcnt <= (nxt != state) ? 4'd0 : rcnt + 4'(rsp_hs);
      if (fe6_out.rdy) fe6_out.val <= 1'b0;
      if (res_hs & (cnt < N6)) fe6_out.val <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (in_hs) wbuf[idx] <= fe12_in.dat;
    if (in_hs & fe12_in.sop) ctl_r <= fe12_in.ctl;
    if (rsp_hs) nbuf[sub_rsp.ctl[OVR_WRT_BIT+:3]] <= sub_rsp.dat;
    if (res_hs & (cnt < N6)) begin
      fe6_out.dat <= mul_rsp.dat;
      fe6_out.sop <= (cnt == 4'd0);
      fe6_out.eop <= (cnt == LAST6);
      fe6_out.ctl <= tag_ctl(ctl_r, cnt);
    end
  end
endmodule

// File: tb/tb_bls12_381_fe12_norm_fe6.sv
// tb_bls12_381_fe12_norm_fe6: directed Fp12 frames against hand-computed norms, with Fp12 multiplier and Fp subtractor models
module tb_bls12_381_fe12_norm_fe6;
  import bls12_381_fe12_norm_fe6_pkg::*;
  typedef logic [1:0][380:0] f2_t;
  typedef logic [5:0][380:0] f6_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int n_cmp = 0, n_bad = 0, err_cnt = 0, mul_beats = 0, inj_req = 0;
  bit rev = 0, bp = 0;
  fe_t od[$];
  logic os[$], oe[$];
  logic [761:0] mreq [12];
  logic msop [12], meop [12];
  always #5 clk = ~clk;
  bls12_381_fe12_norm_fe6_if #(.DAT_BITS(381)) fe12_in();
  bls12_381_fe12_norm_fe6_if #(.DAT_BITS(381)) fe6_out();
  bls12_381_fe12_norm_fe6_if #(.DAT_BITS(762)) sub_req();
  bls12_381_fe12_norm_fe6_if #(.DAT_BITS(381)) sub_rsp();
  bls12_381_fe12_norm_fe6_if #(.DAT_BITS(762)) mul_req();
  bls12_381_fe12_norm_fe6_if #(.DAT_BITS(381)) mul_rsp();
  bls12_381_fe12_norm_fe6 dut (
    .clk(clk), .rst_n(rst_n), .fe12_in(fe12_in), .fe6_out(fe6_out), .sub_req(sub_req),
    .sub_rsp(sub_rsp), .mul_req(mul_req), .mul_rsp(mul_rsp), .err(err)
  );
  function automatic fe_t fadd(input fe_t a, input fe_t b);
    logic [381:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[380:0];
  endfunction
  function automatic fe_t fsub(input fe_t a, input fe_t b);
    logic [381:0] s;
    s = {1'b0, a} + {1'b0, P} - {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[380:0];
  endfunction
  function automatic fe_t fmul(input fe_t a, input fe_t b);
    logic [761:0] t;
    t = (762'(a) * 762'(b)) % 762'(P);
    return t[380:0];
  endfunction
  function automatic f2_t f2add(input f2_t a, input f2_t b);
    f2_t r;
    r[0] = fadd(a[0], b[0]);
    r[1] = fadd(a[1], b[1]);
    return r;
  endfunction
  function automatic f2_t f2mul(input f2_t a, input f2_t b);
    f2_t r;
    r[0] = fsub(fmul(a[0], b[0]), fmul(a[1], b[1]));
    r[1] = fadd(fmul(a[0], b[1]), fmul(a[1], b[0]));
    return r;
  endfunction
  function automatic f2_t f2xi(input f2_t x);
    f2_t r;
    r[0] = fsub(x[0], x[1]);
    r[1] = fadd(x[0], x[1]);
    return r;
  endfunction
  function automatic f6_t f6add(input f6_t a, input f6_t b);
    f6_t r;
    for (int i = 0; i < 3; i++) r[2*i+:2] = f2add(a[2*i+:2], b[2*i+:2]);
    return r;
  endfunction
  function automatic f6_t f6v(input f6_t x);
    f6_t r;
    r[1:0] = f2xi(x[5:4]);
    r[3:2] = x[1:0];
    r[5:4] = x[3:2];
    return r;
  endfunction
  function automatic f6_t f6mul(input f6_t a, input f6_t b);
    f6_t r;
    r[1:0] = f2add(f2mul(a[1:0], b[1:0]), f2xi(f2add(f2mul(a[3:2], b[5:4]), f2mul(a[5:4], b[3:2]))));
    r[3:2] = f2add(f2add(f2mul(a[1:0], b[3:2]), f2mul(a[3:2], b[1:0])), f2xi(f2mul(a[5:4], b[5:4])));
    r[5:4] = f2add(f2add(f2mul(a[1:0], b[5:4]), f2mul(a[3:2], b[3:2])), f2mul(a[5:4], b[1:0]));
    return r;
  endfunction
  function automatic fe12_t f12mul(input fe12_t a, input fe12_t b);
    fe12_t r;
    r[5:0] = f6add(f6mul(a[5:0], b[5:0]), f6v(f6mul(a[11:6], b[11:6])));
    r[11:6] = f6add(f6mul(a[5:0], b[11:6]), f6mul(a[11:6], b[5:0]));
    return r;
  endfunction
  initial begin : sub_model
    fe_t d [6];
    logic [3:0] t [6];
    int n, k;
    sub_req.rdy = 1'b1;
    sub_rsp.val = 1'b0; sub_rsp.sop = 1'b1; sub_rsp.eop = 1'b1; sub_rsp.dat = '0; sub_rsp.ctl = '0;
    forever begin
      n = 0;
      while (n < 6) begin
        @(negedge clk);
        if (sub_req.val && sub_req.rdy) begin
          d[n] = fsub(sub_req.dat[380:0], sub_req.dat[761:381]);
          t[n] = sub_req.ctl[OVR_WRT_BIT+:4];
          n++;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
        k = rev ? 5 - i : i;
        sub_rsp.val = 1'b1; sub_rsp.dat = d[k]; sub_rsp.ctl = '0; sub_rsp.ctl[OVR_WRT_BIT+:4] = t[k];
        @(posedge clk); #1;
      end
      sub_rsp.val = 1'b0;
    end
  end
  initial begin : mul_model
    fe12_t a, b, p;
    int n, w, seen;
    seen = 0;
    mul_req.rdy = 1'b1;
    mul_rsp.val = 1'b0; mul_rsp.sop = 1'b0; mul_rsp.eop = 1'b0; mul_rsp.dat = '0; mul_rsp.ctl = '0;
    forever begin
      n = 0;
      while (n < 12) begin
        @(negedge clk);
        if (inj_req != seen) begin
          seen = inj_req;
          @(posedge clk); #1;
          mul_rsp.val = 1'b1; mul_rsp.dat = 381'h5; mul_rsp.sop = 1'b1; mul_rsp.eop = 1'b0;
          w = 0;
          @(negedge clk);
          while (!mul_rsp.rdy && w < 20) begin @(negedge clk); w++; end
          @(posedge clk); #1;
          mul_rsp.val = 1'b0;
        end else if (mul_req.val && mul_req.rdy) begin
          if (mul_req.sop) n = 0;
          mreq[n] = mul_req.dat; msop[n] = mul_req.sop; meop[n] = mul_req.eop;
          a[n] = mul_req.dat[380:0]; b[n] = mul_req.dat[761:381];
          n++; mul_beats++;
        end
      end
      p = f12mul(a, b);
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
        mul_rsp.val = 1'b1; mul_rsp.dat = p[i]; mul_rsp.sop = (i == 0); mul_rsp.eop = (i == 11);
        w = 0;
        @(negedge clk);
        while (!mul_rsp.rdy && w < 1000) begin @(negedge clk); w++; end
        @(posedge clk); #1;
      end
      mul_rsp.val = 1'b0;
    end
  end
  initial begin : sink
    fe6_out.rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (err) err_cnt++;
      if (fe6_out.val && fe6_out.rdy) begin
        od.push_back(fe6_out.dat); os.push_back(fe6_out.sop); oe.push_back(fe6_out.eop);
      end
      @(posedge clk); #1;
      fe6_out.rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  task automatic send_frame(input fe12_t f, input int len);
    int w;
    for (int i = 0; i < len; i++) begin
      fe12_in.val = 1'b1; fe12_in.dat = f[i]; fe12_in.sop = (i == 0); fe12_in.eop = (i == len - 1);
      fe12_in.ctl = 32'h00a0_0005;
      w = 0;
      @(negedge clk);
      while (!fe12_in.rdy && w < 2000) begin @(negedge clk); w++; end
      if (w >= 2000) begin n_cmp++; n_bad++; $display("FAIL in_rdy_timeout: beat %0d never accepted", i); end
      @(posedge clk); #1;
    end
    fe12_in.val = 1'b0; fe12_in.sop = 1'b0; fe12_in.eop = 1'b0;
  endtask
  task automatic check6(input string nm, input f6_t e);
    int w;
    fe_t d;
    logic s, t;
    w = 0;
    while (od.size() < 6 && w < 3000) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (od.size() < 6) begin
      n_bad++;
      $display("FAIL %s_count: got %0d beats, want 6", nm, od.size());
      od.delete(); os.delete(); oe.delete();
    end else
      for (int i = 0; i < 6; i++) begin
        d = od.pop_front(); s = os.pop_front(); t = oe.pop_front();
        n_cmp++;
        if (d !== e[i] || s !== (i == 0) || t !== (i == 5)) begin
          n_bad++;
          $display("FAIL %s_beat%0d: got dat=%h sop=%b eop=%b, want dat=%h sop=%b eop=%b", nm, i, d, s, t, e[i], i == 0, i == 5);
        end
      end
  endtask
  task automatic test_reset();
    fe12_in.val = 1'b0; fe12_in.sop = 1'b0; fe12_in.eop = 1'b0; fe12_in.dat = '0; fe12_in.ctl = '0;
    #12;
    n_cmp++;
    if ({fe12_in.rdy, sub_rsp.rdy, mul_rsp.rdy} !== 3'b000) begin n_bad++; $display("FAIL reset_rdy: got %b, want 000", {fe12_in.rdy, sub_rsp.rdy, mul_rsp.rdy}); end
    n_cmp++;
    if ({fe6_out.val, sub_req.val, mul_req.val} !== 3'b000) begin n_bad++; $display("FAIL reset_val: got %b, want 000", {fe6_out.val, sub_req.val, mul_req.val}); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b, want 0", err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (fe12_in.rdy !== 1'b1) begin n_bad++; $display("FAIL load_rdy: got %b, want 1", fe12_in.rdy); end
  endtask
  task automatic test_one();
    f6_t e = '0;
    e[0] = 381'd1;
    send_frame(FE12_one, 12);
    check6("one", e);
    n_cmp++;
    if (err_cnt != 0) begin n_bad++; $display("FAIL one_err: got %0d pulses, want 0", err_cnt); end
  endtask
  task automatic test_sparse();
    fe12_t f = '0;
    f6_t e = '0;
    f[0] = 381'd3; f[6] = 381'd1;
    e[0] = 381'd9; e[2] = P - 381'd1;
    send_frame(f, 12);
    check6("sparse", e);
    n_cmp++;
    if (mreq[0] !== {fe_t'(3), fe_t'(3)} || msop[0] !== 1'b1) begin n_bad++; $display("FAIL mul_beat0: got %h sop=%b, want {3,3} sop=1", mreq[0], msop[0]); end
    n_cmp++;
    if (mreq[6] !== {fe_t'(P - 381'd1), fe_t'(1)}) begin n_bad++; $display("FAIL mul_beat6: got %h, want {P-1,1}", mreq[6]); end
    n_cmp++;
    if (mreq[7] !== '0 || meop[11] !== 1'b1) begin n_bad++; $display("FAIL mul_beat7_eop: got %h eop11=%b, want 0 eop11=1", mreq[7], meop[11]); end
  endtask
  task automatic test_c0v();
    fe12_t f = '0;
    f6_t e = '0;
    f[0] = 381'd2; f[2] = 381'd1;
    e[0] = 381'd4; e[2] = 381'd4; e[4] = 381'd1;
    send_frame(f, 12);
    check6("c0v", e);
  endtask
  task automatic test_back_to_back();
    fe12_t f1 = '0, f2 = '0;
    f6_t e1 = '0, e2 = '0;
    f1[8] = 381'd1; e1[0] = P - 381'd1; e1[1] = P - 381'd1;
    f2[7] = 381'd1; e2[2] = 381'd1;
    rev = 1; bp = 1;
    send_frame(f1, 12);
    send_frame(f2, 12);
    check6("b2b_c1v", e1);
    check6("b2b_c1u", e2);
    rev = 0; bp = 0;
  endtask
  task automatic test_short();
    int e0 = err_cnt, m0 = mul_beats;
    f6_t e = '0;
    e[0] = 381'd1;
    send_frame(FE12_one, 7);
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (err_cnt != e0 + 1) begin n_bad++; $display("FAIL short_err: got %0d pulses, want 1", err_cnt - e0); end
    n_cmp++;
    if (mul_beats != m0 || od.size() != 0) begin n_bad++; $display("FAIL short_quiet: got %0d mul beats %0d out beats, want 0 0", mul_beats - m0, od.size()); end
    send_frame(FE12_one, 12);
    check6("after_short", e);
  endtask
  task automatic test_reset_mid();
    fe12_t f = '0, g = '0;
    f6_t e = '0;
    int m0 = mul_beats, w = 0;
    f[0] = 381'd2; f[2] = 381'd1;
    g[0] = 381'd3; g[6] = 381'd1;
    e[0] = 381'd9; e[2] = P - 381'd1;
    send_frame(f, 12);
    while (mul_beats < m0 + 4 && w < 2000) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (mul_beats < m0 + 4) begin n_bad++; $display("FAIL mid_mult_timeout: got %0d mul beats, want 4", mul_beats - m0); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    inj_req++;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (od.size() != 0) begin n_bad++; $display("FAIL abandon_out: got %0d beats, want 0", od.size()); end
    send_frame(g, 12);
    check6("after_reset", e);
  endtask
  initial begin
    test_reset();
    test_one();
    test_sparse();
    test_c0v();
    test_back_to_back();
    test_short();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
